qspi_flash_responder: RTL and testbench
=======================================

QSPI_FLASH_RESPONDER -- requirements
Module: qspi_flash_responder

Interface
REQ-001 The block SHALL have parameter DUMMY_CYCLES, default 8, SCK cycles between the last address bit and the first data output for command 0x6B.
REQ-002 The block SHALL have parameter JEDEC_ID, default 24'hEF4018, the 3 ID bytes returned MSB-first for command 0x9F.
REQ-003 Port mclk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 Port RESETn, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port sck, input, 1 bit: SPI clock from the master, asynchronous to mclk, mode 0; its frequency does not exceed mclk/8.
REQ-006 Port cs_n, input, 1 bit: active-low chip select from the master, asynchronous.
REQ-007 Port io_in, input, 4 bits: sampled IO3..IO0 pad values.
REQ-008 Port io_out, output, 4 bits: values driven onto IO3..IO0.
REQ-009 Port io_oe, output, 4 bits: per-pin output enable, 1 = drive.
REQ-010 Port mem_rd, output, 1 bit: one-cycle read strobe to the backing store.
REQ-011 Port mem_addr, output, 24 bits: byte address, valid while mem_rd = 1.
REQ-012 Port mem_rdata, input, 8 bits: read data, valid exactly 1 mclk cycle after mem_rd.
REQ-013 Port busy, output, 1 bit: high while a transaction is in progress (cs_n low, synchronized).
REQ-014 Port cmd_err, output, 1 bit: one-cycle pulse on receipt of an unsupported opcode.

Function
REQ-015 sck and cs_n SHALL each pass through a 2-flop synchronizer; sck rising and falling edges SHALL be detected from the synchronized value.
REQ-016 io_in SHALL be sampled on detected sck rising edges; io_out SHALL update on detected sck falling edges.
REQ-017 The FSM SHALL have the states IDLE, CMD, ADDR, DUMMY, DATA_1, DATA_4, ID and IGNORE.
REQ-018 IDLE SHALL move to CMD on the synchronized falling edge of cs_n.
REQ-019 CMD SHALL shift 8 bits from io_in[0], MSB first.
REQ-020 On the 8th CMD bit the FSM SHALL go to ADDR for opcode 0x03 or 0x6B, to ID for 0x9F, and otherwise to IGNORE with a cmd_err pulse.
REQ-021 ADDR SHALL shift 24 bits from io_in[0], MSB first.
REQ-022 On the 24th ADDR bit the block SHALL assert mem_rd with mem_addr = the shifted address.
REQ-023 After ADDR, opcode 0x03 SHALL go to DATA_1; opcode 0x6B SHALL go to DUMMY and then to DATA_4 after DUMMY_CYCLES rising edges.
REQ-024 DUMMY_CYCLES = 0 SHALL skip DUMMY.
REQ-025 DATA_1 SHALL drive io_out[1] MSB-first with io_oe = 4'b0010; the first bit SHALL be driven on the falling edge that follows the last address bit.
REQ-026 DATA_4 SHALL drive the high nibble then the low nibble on io_out[3:0] with io_oe = 4'b1111.
REQ-027 When a byte is loaded into the output shifter, the next byte SHALL be prefetched: mem_rd is pulsed with address + 1.
REQ-028 The address SHALL wrap from 24'hFFFFFF to 24'h000000.
REQ-029 ID SHALL output the JEDEC_ID bytes on io_out[1], MSB first, then output 0x00 for every further byte.
REQ-030 IGNORE SHALL keep io_oe = 0 until cs_n deasserts.
REQ-031 A cs_n rise in any state SHALL force IDLE, io_oe = 0 and busy = 0 within 3 mclk cycles; any partial byte is discarded.
REQ-032 When an sck edge and a cs_n rise are detected in the same cycle, the cs_n rise SHALL win.
REQ-033 mem_rd SHALL never be asserted in consecutive cycles.

Reset
REQ-034 While RESETn is low: io_out = 0, io_oe = 0, mem_rd = 0, mem_addr = 0, busy = 0, cmd_err = 0, FSM = IDLE, and all shift registers and counters are cleared.
REQ-035 Reset asserted mid-transaction SHALL release the IO pins asynchronously.
REQ-036 After RESETn rises, the block SHALL ignore the current transaction until cs_n has been seen high at least once.

Configuration
REQ-037 With macro QSPI_RESP_READID_EN defined, opcode 0x9F SHALL be supported as in REQ-029.
REQ-038 Without QSPI_RESP_READID_EN, 0x9F SHALL be treated as unsupported (IGNORE plus cmd_err), and the ID state and the JEDEC_ID logic SHALL be absent.

Structure
REQ-039 A shared package qspi_pkg SHALL hold the opcode constants (OP_READ = 0x03, OP_QREAD = 0x6B, OP_RDID = 0x9F), the FSM state encoding, and ADDR_W = 24.
REQ-040 One sub-module, qspi_sync_edge, SHALL implement the 2-flop synchronizer plus rise/fall detection, and SHALL be instantiated for sck and for cs_n.

Verification
REQ-041 Read 0x03, address 0x000010, store[0x10..0x12] = A5,3C,FF: io_out[1] yields A5 3C FF; mem_rd is seen at addresses 0x10, 0x11, 0x12, 0x13.
REQ-042 Quad read 0x6B, address 0x000100, DUMMY_CYCLES = 8, 4 bytes: io_oe stays 0 for 8 SCK after the address; nibbles on io_out[3:0] match the store; io_oe = 1111 during data.
REQ-043 0x03 at address 0xFFFFFF, 2 bytes: the second mem_addr is 0x000000.
REQ-044 0x9F with the macro defined: EF 40 18 00. Without the macro: cmd_err pulses once and io_oe stays 0.
REQ-045 cs_n raised after 3 bits of data byte 2: io_oe = 0 within 3 mclk cycles; a following 0x03 transaction starts cleanly in CMD.
REQ-046 RESETn pulsed low mid-DATA_4: io_oe drops immediately; the remaining SCKs while cs_n is still low are ignored; the next transaction after cs_n high completes normally.

Source files
------------

// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - opcodes, FSM state encoding and address width shared by the QSPI flash responder
package qspi_pkg;

  localparam int ADDR_W = 24;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_QREAD = 8'h6B;
  localparam logic [7:0] OP_RDID  = 8'h9F;

  localparam logic [3:0] OE_SINGLE = 4'b0010;
  localparam logic [3:0] OE_QUAD   = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA_1 = 3'd4,
    ST_DATA_4 = 3'd5,
    ST_ID     = 3'd6,
    ST_IGNORE = 3'd7
  } qspi_state_t;

endpackage

// File: rtl/qspi_sync_edge.sv
// rtl/qspi_sync_edge.sv - 2-flop synchronizer with rise/fall detection on the synchronized value
module qspi_sync_edge (
  input  logic mclk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resetting to 0 means a line held low through reset never produces a fall
  // until it has first been seen high.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/qspi_flash_responder.sv
// rtl/qspi_flash_responder.sv - QSPI flash responder serving 0x03/0x6B reads from a backing store
// Optional feature macro QSPI_RESP_READID_EN adds 0x9F read-ID and the JEDEC_ID parameter.
module qspi_flash_responder
  import qspi_pkg::*;
#(
  parameter int DUMMY_CYCLES = 8
`ifdef QSPI_RESP_READID_EN
  ,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
`endif
) (
  input  logic              mclk,
  input  logic              RESETn,
  input  logic              sck,
  input  logic              cs_n,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  qspi_sync_edge u_sck_sync (
    .mclk     (mclk),
    .rst_n    (RESETn),
    .async_in (sck),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  qspi_sync_edge u_cs_sync (
    .mclk     (mclk),
    .rst_n    (RESETn),
    .async_in (cs_n),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  qspi_state_t state_q, state_d;
  logic        cmd_err_d;
  logic [7:0]  opcode_q;
  logic [22:0] shift_q;
  logic [4:0]  bit_cnt;
  logic [7:0]  dummy_cnt;
  logic [7:0]  out_sh;
  logic [2:0]  out_cnt;
  logic        rd_q;
  logic [7:0]  rbuf;
  logic [7:0]  cmd_word;
  logic [23:0] addr_word;
  logic        unused_io;

  // Address and opcode always arrive on IO0, so the upper pads are not sampled.
  assign unused_io = ^io_in[3:1];
  assign cmd_word  = {shift_q[6:0], io_in[0]};
  assign addr_word = {shift_q, io_in[0]};
  assign busy      = (state_q != ST_IDLE);

`ifdef QSPI_RESP_READID_EN
  logic [1:0] id_idx;
  logic [7:0] id_byte;

  always_comb begin
    id_byte = 8'h00;
    case (id_idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  always_ff @(posedge mclk or negedge RESETn) begin
    if (!RESETn) begin
      id_idx <= 2'd0;
    end else if (cs_rise || state_q == ST_IDLE) begin
      id_idx <= 2'd0;
    end else if (state_q == ST_ID && sck_fall && out_cnt == 3'd0 && id_idx != 2'd3) begin
      id_idx <= id_idx + 2'd1;
    end
  end
`endif

  // A cs_n rise overrides every other transition, including a same-cycle sck edge.
  always_comb begin
    state_d   = state_q;
    cmd_err_d = 1'b0;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (sck_rise && bit_cnt == 5'd7) begin
            case (cmd_word)
              OP_READ, OP_QREAD: state_d = ST_ADDR;
`ifdef QSPI_RESP_READID_EN
              OP_RDID: state_d = ST_ID;
`endif
              default: begin
                state_d   = ST_IGNORE;
                cmd_err_d = 1'b1;
              end
            endcase
          end
        end
        ST_ADDR: begin
          if (sck_rise && bit_cnt == 5'd23) begin
            if (opcode_q == OP_READ) state_d = ST_DATA_1;
            else if (DUMMY_CYCLES == 0) state_d = ST_DATA_4;
            else state_d = ST_DUMMY;
          end
        end
        ST_DUMMY: if (sck_rise && dummy_cnt == DUMMY_LAST) state_d = ST_DATA_4;
        default: ;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= ST_IDLE;
      cmd_err   <= 1'b0;
      opcode_q  <= 8'h00;
      shift_q   <= '0;
      bit_cnt   <= 5'd0;
      dummy_cnt <= 8'd0;
      out_sh    <= 8'h00;
      out_cnt   <= 3'd0;
      rd_q      <= 1'b0;
      rbuf      <= 8'h00;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      io_out    <= 4'h0;
      io_oe     <= 4'h0;
    end else begin
      state_q <= state_d;
      cmd_err <= cmd_err_d;
      mem_rd  <= 1'b0;
      rd_q    <= mem_rd;
      if (rd_q) rbuf <= mem_rdata;

      if (cs_rise || state_q == ST_IDLE) begin
        shift_q   <= '0;
        bit_cnt   <= 5'd0;
        dummy_cnt <= 8'd0;
        out_sh    <= 8'h00;
        out_cnt   <= 3'd0;
        io_out    <= 4'h0;
        io_oe     <= 4'h0;
      end else begin
        case (state_q)
          ST_CMD: begin
            if (sck_rise) begin
              shift_q <= {shift_q[21:0], io_in[0]};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                opcode_q <= cmd_word;
                bit_cnt  <= 5'd0;
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              shift_q <= {shift_q[21:0], io_in[0]};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd23) begin
                mem_rd   <= 1'b1;
                mem_addr <= addr_word;
                bit_cnt  <= 5'd0;
              end
            end
          end
          ST_DUMMY: if (sck_rise) dummy_cnt <= dummy_cnt + 8'd1;
          // Loading a byte consumes the prefetch buffer and immediately refills it.
          ST_DATA_1: begin
            if (sck_fall) begin
              io_oe <= OE_SINGLE;
              if (out_cnt == 3'd0) begin
                io_out   <= {2'b00, rbuf[7], 1'b0};
                out_sh   <= {rbuf[6:0], 1'b0};
                out_cnt  <= 3'd7;
                mem_rd   <= 1'b1;
                mem_addr <= mem_addr + 24'd1;
              end else begin
                io_out  <= {2'b00, out_sh[7], 1'b0};
                out_sh  <= {out_sh[6:0], 1'b0};
                out_cnt <= out_cnt - 3'd1;
              end
            end
          end
          ST_DATA_4: begin
            if (sck_fall) begin
              io_oe <= OE_QUAD;
              if (out_cnt == 3'd0) begin
                io_out   <= rbuf[7:4];
                out_sh   <= {rbuf[3:0], 4'h0};
                out_cnt  <= 3'd1;
                mem_rd   <= 1'b1;
                mem_addr <= mem_addr + 24'd1;
              end else begin
                io_out  <= out_sh[7:4];
                out_sh  <= {out_sh[3:0], 4'h0};
                out_cnt <= out_cnt - 3'd1;
              end
            end
          end
`ifdef QSPI_RESP_READID_EN
          ST_ID: begin
            if (sck_fall) begin
              io_oe <= OE_SINGLE;
              if (out_cnt == 3'd0) begin
                io_out  <= {2'b00, id_byte[7], 1'b0};
                out_sh  <= {id_byte[6:0], 1'b0};
                out_cnt <= 3'd7;
              end else begin
                io_out  <= {2'b00, out_sh[7], 1'b0};
                out_sh  <= {out_sh[6:0], 1'b0};
                out_cnt <= out_cnt - 3'd1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb/tb_qspi_flash_responder.sv - scoreboard bench for qspi_flash_responder with directed transactions
`timescale 1ns/1ps
module tb_qspi_flash_responder;

  localparam int HALF = 50;

  logic        mclk = 1'b0;
  logic        RESETn;
  logic        sck;
  logic        cs_n;
  logic [3:0]  io_in;
  logic [3:0]  io_out;
  logic [3:0]  io_oe;
  logic        mem_rd;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        cmd_err;

  typedef struct packed {
    logic       quad;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] addr_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  int exp_err = 0;

  always #5 mclk = ~mclk;

  qspi_flash_responder #(.DUMMY_CYCLES(8)) dut (
    .mclk      (mclk),
    .RESETn    (RESETn),
    .sck       (sck),
    .cs_n      (cs_n),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oe     (io_oe),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  function automatic logic [7:0] store(input logic [23:0] a);
    case (a)
      24'h000010: store = 8'hA5;
      24'h000011: store = 8'h3C;
      24'h000012: store = 8'hFF;
      24'h000100: store = 8'h12;
      24'h000101: store = 8'h34;
      24'h000102: store = 8'h56;
      24'h000103: store = 8'h78;
      24'hFFFFFF: store = 8'h81;
      24'h000000: store = 8'h7E;
      default:    store = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge mclk) if (mem_rd) mem_rdata <= store(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Byte monitor: collects what the master samples on each sck rise.
  int         cs_epoch = 0;
  int         mon_epoch = 0;
  int         mon_bits = 0;
  logic [7:0] mon_byte = 8'h00;
  logic       mon_quad = 1'b0;

  always @(posedge cs_n or negedge RESETn) cs_epoch = cs_epoch + 1;

  always @(posedge sck) begin
    exp_t e;
    if (mon_epoch != cs_epoch) begin
      mon_bits  = 0;
      mon_quad  = 1'b0;
      mon_epoch = cs_epoch;
    end
    if (io_oe == 4'b0010) begin
      mon_byte = {mon_byte[6:0], io_out[1]};
      mon_bits = mon_bits + 1;
    end else if (io_oe == 4'b1111) begin
      mon_byte = {mon_byte[3:0], io_out};
      mon_bits = mon_bits + 4;
      mon_quad = 1'b1;
    end else if (io_oe != 4'b0000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL io_oe_pattern: got %b, want 0000/0010/1111", io_oe);
    end
    if (mon_bits >= 8) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_byte: got %h (quad=%0d), want no byte", mon_byte, mon_quad);
      end else begin
        e = exp_q.pop_front();
        check("rx_byte", 32'({mon_quad, mon_byte}), 32'(e));
      end
      mon_bits = 0;
      mon_quad = 1'b0;
    end
  end

  // Read-strobe monitor.
  logic prev_rd = 1'b0;
  always @(negedge mclk) begin
    if (mem_rd && prev_rd) begin
      n_cmp++;
      n_bad++;
      $display("FAIL mem_rd_consecutive: got two cycles, want one");
    end
    if (mem_rd) begin
      if (addr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mem_addr: got %h, want no read", mem_addr);
      end else begin
        check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
    end
    if (cmd_err) err_pulses = err_pulses + 1;
    prev_rd = mem_rd;
  end

  task automatic sck_cycle(input logic [3:0] d, input bit last);
    io_in = d;
    #HALF;
    sck = 1'b1;
    #HALF;
    sck = 1'b0;
    if (last) cs_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]}, 1'b0);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) sck_cycle({3'b000, a[i]}, 1'b0);
  endtask

  task automatic start_txn(input logic [7:0] op);
    cs_n = 1'b0;
    #(HALF * 2);
    send_byte(op);
  endtask

  task automatic data_cycles(input int n);
    for (int i = 0; i < n; i++) sck_cycle(4'h0, i == n - 1);
  endtask

  task automatic quiet_cycles(input int n, input bit last, input string name);
    for (int i = 0; i < n; i++) begin
      io_in = 4'h0;
      #HALF;
      check(name, 32'(io_oe), 32'h0);
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
      if (last && i == n - 1) cs_n = 1'b1;
    end
  endtask

  task automatic idle();
    io_in = 4'h0;
    #(HALF * 4);
  endtask

  task automatic exp_byte(input logic [7:0] d, input logic q);
    exp_q.push_back({q, d});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    RESETn = 1'b0;
    cs_n   = 1'b1;
    sck    = 1'b0;
    io_in  = 4'h0;
    #22;
    check("rst_io_out",   32'(io_out),   32'h0);
    check("rst_io_oe",    32'(io_oe),    32'h0);
    check("rst_mem_rd",   32'(mem_rd),   32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_cmd_err",  32'(cmd_err),  32'h0);
    #10;
    RESETn = 1'b1;
    idle();

    // Single read at 0x10, three bytes.
    addr_q.push_back(24'h000010); addr_q.push_back(24'h000011);
    addr_q.push_back(24'h000012); addr_q.push_back(24'h000013);
    exp_byte(8'hA5, 1'b0); exp_byte(8'h3C, 1'b0); exp_byte(8'hFF, 1'b0);
    start_txn(8'h03);
    send_addr(24'h000010);
    check("busy_active", 32'(busy), 32'h1);
    data_cycles(24);
    idle();
    check("busy_idle", 32'(busy), 32'h0);

    // Quad read at 0x100 with 8 dummy cycles, four bytes.
    addr_q.push_back(24'h000100); addr_q.push_back(24'h000101);
    addr_q.push_back(24'h000102); addr_q.push_back(24'h000103);
    addr_q.push_back(24'h000104);
    exp_byte(8'h12, 1'b1); exp_byte(8'h34, 1'b1);
    exp_byte(8'h56, 1'b1); exp_byte(8'h78, 1'b1);
    start_txn(8'h6B);
    send_addr(24'h000100);
    quiet_cycles(8, 1'b0, "dummy_oe");
    data_cycles(8);
    idle();

    // Address wrap at the top of the space.
    addr_q.push_back(24'hFFFFFF); addr_q.push_back(24'h000000);
    addr_q.push_back(24'h000001);
    exp_byte(8'h81, 1'b0); exp_byte(8'h7E, 1'b0);
    start_txn(8'h03);
    send_addr(24'hFFFFFF);
    data_cycles(16);
    idle();

    // Read ID.
`ifdef QSPI_RESP_READID_EN
    exp_byte(8'hEF, 1'b0); exp_byte(8'h40, 1'b0);
    exp_byte(8'h18, 1'b0); exp_byte(8'h00, 1'b0);
    start_txn(8'h9F);
    data_cycles(32);
`else
    start_txn(8'h9F);
    quiet_cycles(32, 1'b1, "rdid_oe");
    exp_err = exp_err + 1;
`endif
    idle();
    check("rdid_cmd_err", 32'(err_pulses), 32'(exp_err));

    // Unsupported opcode.
    start_txn(8'h55);
    quiet_cycles(16, 1'b1, "bad_op_oe");
    exp_err = exp_err + 1;
    idle();
    check("bad_op_cmd_err", 32'(err_pulses), 32'(exp_err));

    // Abort after 3 bits of the second data byte.
    addr_q.push_back(24'h000010); addr_q.push_back(24'h000011);
    addr_q.push_back(24'h000012);
    exp_byte(8'hA5, 1'b0);
    start_txn(8'h03);
    send_addr(24'h000010);
    data_cycles(11);
    repeat (3) @(posedge mclk);
    #1;
    check("abort_oe", 32'(io_oe), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    #6;
    idle();
    addr_q.push_back(24'h000010); addr_q.push_back(24'h000011);
    exp_byte(8'hA5, 1'b0);
    start_txn(8'h03);
    send_addr(24'h000010);
    data_cycles(8);
    idle();

    // Reset pulse in the middle of quad data.
    addr_q.push_back(24'h000100); addr_q.push_back(24'h000101);
    addr_q.push_back(24'h000102);
    exp_byte(8'h12, 1'b1);
    start_txn(8'h6B);
    send_addr(24'h000100);
    quiet_cycles(8, 1'b0, "dummy2_oe");
    for (int i = 0; i < 3; i++) sck_cycle(4'h0, 1'b0);
    #HALF;
    RESETn = 1'b0;
    #1;
    check("reset_oe", 32'(io_oe), 32'h0);
    check("reset_io_out", 32'(io_out), 32'h0);
    #19;
    RESETn = 1'b1;
    quiet_cycles(5, 1'b1, "post_reset_oe");
    check("post_reset_busy", 32'(busy), 32'h0);
    idle();

    addr_q.push_back(24'h000011); addr_q.push_back(24'h000012);
    addr_q.push_back(24'h000013);
    exp_byte(8'h3C, 1'b0); exp_byte(8'hFF, 1'b0);
    start_txn(8'h03);
    send_addr(24'h000011);
    data_cycles(16);
    idle();

    check("bytes_left", 32'(exp_q.size()), 32'h0);
    check("reads_left", 32'(addr_q.size()), 32'h0);
    check("cmd_err_total", 32'(err_pulses), 32'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
